// File: rtl/cache_block_server.sv
// cache_block_server: memory-side responder for the cache manager's block
// interface. Each accepted block request is serialised into BLOCK_SIZE
// ascending single-word accesses on a 32-bit req/ack backing-memory port.
//
// Handshakes:
//   Request side: ram_en is sampled only in IDLE. Its acceptance latches
//   the address, the direction and (for writes) the block. ram_ready pulses
//   for one cycle in DONE when the whole block has been transferred.
//   Memory side: mem_req is the valid signal and mem_ack is the ready
//   signal. A word moves on a cycle with mem_req=1 and mem_ack=1.
//   mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and
//   mem_ack=0. mem_ack is ignored while mem_req=0.
module cache_block_server #(
    parameter int OFFSET_WIDTH = 3,
    parameter int BLOCK_SIZE   = 1 << OFFSET_WIDTH,
    parameter int ADDR_WIDTH   = 30
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ram_en,
    input  logic                    ram_write,
    input  logic [ADDR_WIDTH-1:0]   ram_addr,
    input  logic [32*BLOCK_SIZE-1:0] data_wb,
    output logic [32*BLOCK_SIZE-1:0] data_to_cache,
    output logic                    ram_ready,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [31:0]             mem_wdata,
    input  logic [31:0]             mem_rdata,
    input  logic                    mem_ack,
    output logic [1:0]              state_dbg
);

    localparam int BASE_W = ADDR_WIDTH - OFFSET_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [OFFSET_WIDTH-1:0]  counter;
    logic [BASE_W-1:0]        base;
    logic                     op;
    logic [32*BLOCK_SIZE-1:0] wb_buf;
    logic                     accept;
    logic                     word_done;
    logic                     last_word;
    logic                     unused_offset;

    // The offset bits of the request address are ignored because blocks
    // are always aligned.
    assign unused_offset = ^ram_addr[OFFSET_WIDTH-1:0];

    assign last_word = (counter == {OFFSET_WIDTH{1'b1}});
    assign mem_addr  = {base, counter};
    assign mem_wdata = wb_buf[32*counter +: 32];
    assign state_dbg = state;

    // State register. Reset abandons any in-flight transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and the control outputs decoded from the current state.
    always_comb begin
        state_nxt = state;
        ram_ready = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        accept    = 1'b0;
        word_done = 1'b0;
        case (state)
            IDLE: begin
                if (ram_en) begin
                    accept    = 1'b1;
                    state_nxt = XFER;
                end
            end
            XFER: begin
                mem_req = 1'b1;
                mem_we  = op;
                if (mem_ack) begin
                    word_done = 1'b1;
                    if (last_word) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                ram_ready = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: latch the request on accept, step the word counter on each
    // acknowledged word, and fill the refill block during reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter       <= '0;
            base          <= '0;
            op            <= 1'b0;
            wb_buf        <= '0;
            data_to_cache <= '0;
        end else begin
            if (accept) begin
                base    <= ram_addr[ADDR_WIDTH-1:OFFSET_WIDTH];
                op      <= ram_write;
                counter <= '0;
                if (ram_write) begin
                    wb_buf <= data_wb;
                end
            end else if (word_done) begin
                if (!op) begin
                    data_to_cache[32*counter +: 32] <= mem_rdata;
                end
                counter <= last_word ? '0 : counter + 1'b1;
            end
        end
    end

endmodule

// File: doc/cache_block_server.md
Name: cache_block_server

Overview:
- Memory-side responder for the cache manager's block-transfer interface.
- Accepts block read (refill) and block write-back requests via `ram_en`/`ram_write`/`ram_addr`/`data_wb`.
- Serialises each request into 8 single-word accesses on a 32-bit req/ack backing-memory port; assembles or disassembles the 256-bit block.
- Pulses `ram_ready` for one cycle when the whole block is done; sits between the cache manager and main memory/DDR bridge.

Parameters:
- OFFSET_WIDTH, 3, log2 of words per block
- BLOCK_SIZE, 1<<OFFSET_WIDTH, words per block
- ADDR_WIDTH, 30, word-address width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ram_en  in  1  request valid from cache manager
- ram_write  in  1  1 = block write-back, 0 = block read
- ram_addr  in  ADDR_WIDTH  word address; low OFFSET_WIDTH bits ignored (block aligned)
- data_wb  in  32*BLOCK_SIZE  write-back block; word i at [32i+31:32i]
- data_to_cache  out  32*BLOCK_SIZE  refill block, same word layout
- ram_ready  out  1  one-cycle completion pulse
- mem_req  out  1  backing-memory word request
- mem_we  out  1  word write enable
- mem_addr  out  ADDR_WIDTH  word address = {base, word counter}
- mem_wdata  out  32  write word
- mem_rdata  in  32  read word, valid in the cycle mem_ack=1
- mem_ack  in  1  word access complete this cycle

Behaviour:
- Reset (rst=0, async, any state): state=IDLE; counter=0. The following outputs are 0: ram_ready, mem_req, mem_we, mem_addr, mem_wdata, data_to_cache. Any in-flight transfer is abandoned. Release is synchronous to clk.
- States: IDLE, XFER, DONE.
- IDLE: ram_en=1 at a clock edge latches:
  - base = ram_addr[ADDR_WIDTH-1:OFFSET_WIDTH]
  - op = ram_write
  - data_wb into an internal block buffer (write only)
  - counter=0
  - next state = XFER.
- IDLE with ram_en=0: stay in IDLE.
- XFER:
  - mem_req=1, mem_we=op, mem_addr={base,counter}, mem_wdata=buffer word[counter].
  - All mem_* outputs are stable until mem_ack=1.
  - On a cycle with mem_ack=1:
    - read: mem_rdata is written into data_to_cache word[counter].
    - if counter==BLOCK_SIZE-1: next state = DONE, counter=0.
    - otherwise counter+1, and mem_req stays 1 (back-to-back allowed).
  - Words always go in ascending order 0..7. The counter never wraps inside a transfer.
- DONE: ram_ready=1 for exactly one cycle, mem_req=0, then IDLE. ram_en is not sampled in DONE. The requester advances on this edge, so its next request is seen in IDLE on the following cycle.
- Latency with zero-wait memory (mem_ack tied 1): ram_en sampled at edge 0, XFER in cycles 1-8, ram_ready in cycle 9, IDLE in cycle 10. Each memory wait cycle adds exactly one cycle.
- Transfers are atomic:
  - ram_en deasserting, or ram_addr/ram_write/data_wb changing, during XFER or DONE is ignored.
  - data_wb is used only from the buffer latched at accept.
- data_to_cache:
  - holds its value after a read completes until the next read overwrites it.
  - is not modified by writes.
  - Words update progressively during a read; the requester may consume them only at or after ram_ready.
- mem_ack while mem_req=0 is ignored.
- A read following a write to the same block returns the written data. This is guaranteed because write completion (ram_ready) follows the final mem_ack.
- Roughly 150-250 lines of RTL.

Test Plan:
- Reset, mem_ack=1, memory word k = 0x1000_0000+k, read ram_addr=0x0000_0045 -> mem_addr 0x40..0x47 in cycles 1-8; ram_ready only in cycle 9; data_to_cache word i = 0x1000_0040+i.
- Write ram_addr=0x0000_0088, data_wb word i = 0xA5A5_0000+i, mem_ack=1 -> mem_we=1, mem_addr 0x88..0x8F carrying 0xA5A5_0000..0007; then read 0x88 returns the same block.
- Read with mem_ack asserted every third cycle -> mem_addr/mem_req held during waits; ram_ready at cycle 25; data correct; exactly one ram_ready pulse.
- Drop ram_en and change ram_addr to 0x100 in cycle 3 of a read at 0x40 -> transfer completes on 0x40..0x47; no request to 0x100 until ram_en is resampled in IDLE.
- Assert rst=0 asynchronously mid-XFER (counter=4) -> mem_req, ram_ready, data_to_cache go 0 immediately without a clock edge; after release with ram_en=1, a new transfer starts at word 0.
- Hold ram_en=1 continuously across two back-to-back reads (0x40 then 0x48) -> second request accepted in the IDLE cycle right after DONE; two ram_ready pulses exactly 10 cycles apart.
